// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_pkg
// Description : Shared definitions for the ALU / register-file pipeline:
//               opcode constants, flag bit indices, the flags typedef and
//               small opcode-decode helpers used by the hazard logic.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pipe_pkg;

    // Opcodes
    localparam logic [7:0] c_OP_ADD  = 8'h00;
    localparam logic [7:0] c_OP_ADDI = 8'h01;
    localparam logic [7:0] c_OP_ADDU = 8'h02;
    localparam logic [7:0] c_OP_SUB  = 8'h08;
    localparam logic [7:0] c_OP_SUBI = 8'h09;
    localparam logic [7:0] c_OP_CMP  = 8'h0A;
    localparam logic [7:0] c_OP_CMPI = 8'h0B;
    localparam logic [7:0] c_OP_AND  = 8'h0D;
    localparam logic [7:0] c_OP_OR   = 8'h0E;
    localparam logic [7:0] c_OP_XOR  = 8'h0F;
    localparam logic [7:0] c_OP_NOT  = 8'h10;
    localparam logic [7:0] c_OP_LSH  = 8'h11;
    localparam logic [7:0] c_OP_RSH  = 8'h13;
    localparam logic [7:0] c_OP_ARSH = 8'h16;
    localparam logic [7:0] c_OP_NOP  = 8'h17;
    localparam logic [7:0] c_OP_LOAD = 8'h99;

    // Bit positions of the flags vector {Z,C,F,L,N}
    localparam int c_FLAG_Z = 4;
    localparam int c_FLAG_C = 3;
    localparam int c_FLAG_F = 2;
    localparam int c_FLAG_L = 1;
    localparam int c_FLAG_N = 0;

    typedef struct packed {
        logic z;    // zero / equal
        logic c;    // carry-out (ADDU)
        logic f;    // signed overflow
        logic l;    // unsigned less-than (CMP)
        logic n;    // signed less-than (CMP)
    } flags_t;

    // Instruction reads its rdest register as operand A
    function automatic logic op_reads_a(input logic [7:0] op);
        return op inside {c_OP_ADD, c_OP_ADDI, c_OP_ADDU, c_OP_SUB, c_OP_SUBI,
                          c_OP_CMP, c_OP_CMPI, c_OP_AND, c_OP_OR, c_OP_XOR,
                          c_OP_NOT, c_OP_LSH, c_OP_RSH, c_OP_ARSH};
    endfunction

    // Instruction reads its rsrc register as operand B (not an immediate)
    function automatic logic op_reads_b(input logic [7:0] op);
        return op inside {c_OP_ADD, c_OP_ADDU, c_OP_SUB, c_OP_CMP, c_OP_AND,
                          c_OP_OR, c_OP_XOR, c_OP_LSH, c_OP_RSH, c_OP_ARSH,
                          c_OP_LOAD};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_pipe_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_core
// Description : Purely combinational ALU. Computes result = a op b, the
//               candidate flags, and whether the opcode updates flags,
//               writes a register, or is a legal opcode at all.
// Ports       : a, b        - operands (WIDTH)
//               opcode      - 8-bit opcode
//               result      - ALU result (WIDTH)
//               flags       - candidate flags {Z,C,F,L,N}
//               flags_we    - opcode updates flags
//               writes_reg  - opcode writes rdest from the ALU result
//               legal       - opcode is defined (LOAD/NOP included)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       opcode,
    output logic [WIDTH-1:0] result,
    output flags_t           flags,
    output logic             flags_we,
    output logic             writes_reg,
    output logic             legal
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf_add;
    logic             w_ovf_sub;
    logic [SW-1:0]    w_amt;

    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_diff    = a - b;
    assign w_ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
    // A zero shift amount encodes a shift by one
    assign w_amt     = (b[SW-1:0] == '0) ? SW'(1) : b[SW-1:0];

    always_comb begin
        result     = '0;
        flags      = '0;
        flags_we   = 1'b0;
        writes_reg = 1'b1;
        legal      = 1'b1;
        case (opcode)
            c_OP_ADD, c_OP_ADDI: begin
                result   = w_sum[WIDTH-1:0];
                flags.z  = (w_sum[WIDTH-1:0] == '0);
                flags.f  = w_ovf_add;
                flags_we = 1'b1;
            end
            c_OP_ADDU: begin
                result   = w_sum[WIDTH-1:0];
                flags.z  = (w_sum[WIDTH-1:0] == '0);
                flags.c  = w_sum[WIDTH];
                flags_we = 1'b1;
            end
            c_OP_SUB, c_OP_SUBI: begin
                result   = w_diff;
                flags.z  = (w_diff == '0);
                flags.f  = w_ovf_sub;
                flags_we = 1'b1;
            end
            c_OP_CMP, c_OP_CMPI: begin
                writes_reg = 1'b0;
                flags.z    = (a == b);
                flags.l    = (a < b);
                flags.n    = ($signed(a) < $signed(b));
                flags_we   = 1'b1;
            end
            c_OP_AND:  result = a & b;
            c_OP_OR:   result = a | b;
            c_OP_XOR:  result = a ^ b;
            c_OP_NOT:  result = ~a;
            c_OP_LSH:  result = a << w_amt;
            c_OP_RSH:  result = a >> w_amt;
            c_OP_ARSH: result = $unsigned($signed(a) >>> w_amt);
            c_OP_NOP:  writes_reg = 1'b0;
            // LOAD data comes from memory; the pipeline handles the write
            c_OP_LOAD: writes_reg = 1'b0;
            default: begin
                writes_reg = 1'b0;
                legal      = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_regfile_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile_pipe
// Description : Two-stage (ID, EX) ALU pipeline with an NREGS x WIDTH
//               register file, LOAD via a simple request/valid memory port,
//               flags register and write-back report.
//               Build option ALU_PIPE_FWD_EN: forward the EX result into ID
//               operand reads instead of inserting RAW hazard bubbles.
// Ports       : clk, reset (async, active-low)
//               in_valid/in_ready/in_instr {opcode, rdest, rsrc}
//               mem_req/mem_addr -> ; mem_valid/mem_data <- (LOAD)
//               wb_valid/wb_addr/wb_data - one pulse per register write
//               flags {Z,C,F,L,N}, illegal_op - one-cycle pulse
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile_pipe
    import alu_pipe_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8+2*AW-1:0] in_instr,
    output logic              mem_req,
    output logic [WIDTH-1:0]  mem_addr,
    input  logic              mem_valid,
    input  logic [WIDTH-1:0]  mem_data,
    output logic              wb_valid,
    output logic [AW-1:0]     wb_addr,
    output logic [WIDTH-1:0]  wb_data,
    output logic [4:0]        flags,
    output logic              illegal_op
);

    localparam int IW = 8 + 2*AW;

    logic [WIDTH-1:0] r_regs [NREGS];

    // ID stage
    logic             r_id_valid;
    logic [IW-1:0]    r_id_instr;
    logic [7:0]       w_id_op;
    logic [AW-1:0]    w_id_rd;
    logic [AW-1:0]    w_id_rs;
    logic [WIDTH-1:0] w_id_a;
    logic [WIDTH-1:0] w_id_rs_val;
    logic [WIDTH-1:0] w_id_b;
    logic             w_id_adv;
    logic             w_hazard;

    // EX stage
    logic             r_ex_valid;
    logic [7:0]       r_ex_op;
    logic [AW-1:0]    r_ex_rd;
    logic [WIDTH-1:0] r_ex_a;
    logic [WIDTH-1:0] r_ex_b;
    logic             w_ex_load;
    logic             w_ex_stall;
    logic             w_ex_done;
    logic             w_wb_en;
    logic [WIDTH-1:0] w_wb_data;

    logic [WIDTH-1:0] w_alu_result;
    flags_t           w_alu_flags;
    logic             w_alu_flags_we;
    logic             w_alu_writes;
    logic             w_alu_legal;
    flags_t           r_flags;

    assign w_id_op = r_id_instr[IW-1 -: 8];
    assign w_id_rd = r_id_instr[2*AW-1 -: AW];
    assign w_id_rs = r_id_instr[AW-1:0];

    // Register reads see a write-back landing on the same edge
    assign w_id_a      = (w_wb_en && r_ex_rd == w_id_rd) ? w_wb_data : r_regs[w_id_rd];
    assign w_id_rs_val = (w_wb_en && r_ex_rd == w_id_rs) ? w_wb_data : r_regs[w_id_rs];

    always_comb begin
        w_id_b = w_id_rs_val;
        if (w_id_op == c_OP_ADDI || w_id_op == c_OP_CMPI)
            w_id_b = {{(WIDTH-AW){w_id_rs[AW-1]}}, w_id_rs};
        else if (w_id_op == c_OP_SUBI)
            w_id_b = {{(WIDTH-AW){1'b0}}, w_id_rs};
    end

`ifdef ALU_PIPE_FWD_EN
    assign w_hazard = 1'b0;
`else
    // RAW on a register the EX instruction will write: hold ID until EX
    // retires, then read the updated register file.
    assign w_hazard = r_id_valid && r_ex_valid && (r_ex_op == c_OP_LOAD || w_alu_writes) &&
                      ((op_reads_a(w_id_op) && w_id_rd == r_ex_rd) ||
                       (op_reads_b(w_id_op) && w_id_rs == r_ex_rd));
`endif

    assign w_ex_load  = (r_ex_op == c_OP_LOAD);
    assign w_ex_stall = r_ex_valid && w_ex_load && !mem_valid;
    assign w_ex_done  = r_ex_valid && !w_ex_stall;
    assign w_wb_en    = w_ex_done && (w_ex_load || w_alu_writes);
    assign w_wb_data  = w_ex_load ? mem_data : w_alu_result;

    assign in_ready = !w_ex_stall && !w_hazard;
    assign w_id_adv = r_id_valid && in_ready;

    assign mem_req  = r_ex_valid && w_ex_load;
    assign mem_addr = r_ex_b;
    assign flags    = r_flags;

    alu_pipe_core #(
        .WIDTH      (WIDTH)
    ) u_core (
        .a          (r_ex_a),
        .b          (r_ex_b),
        .opcode     (r_ex_op),
        .result     (w_alu_result),
        .flags      (w_alu_flags),
        .flags_we   (w_alu_flags_we),
        .writes_reg (w_alu_writes),
        .legal      (w_alu_legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_rd    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_flags    <= '0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            illegal_op <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            if (in_valid && in_ready) begin
                r_id_valid <= 1'b1;
                r_id_instr <= in_instr;
            end else if (w_id_adv) begin
                r_id_valid <= 1'b0;
            end

            if (!w_ex_stall) begin
                r_ex_valid <= w_id_adv;
                if (w_id_adv) begin
                    r_ex_op <= w_id_op;
                    r_ex_rd <= w_id_rd;
                    r_ex_a  <= w_id_a;
                    r_ex_b  <= w_id_b;
                end
            end

            wb_valid <= w_wb_en;
            if (w_wb_en) begin
                r_regs[r_ex_rd] <= w_wb_data;
                wb_addr         <= r_ex_rd;
                wb_data         <= w_wb_data;
            end

            if (w_ex_done && w_alu_flags_we)
                r_flags <= w_alu_flags;

            illegal_op <= w_ex_done && !w_alu_legal;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_regfile_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_regfile_pipe
// Description : Directed self-checking bench for alu_regfile_pipe
//               (WIDTH=16, NREGS=16, instr = {op[7:0], rd[3:0], rs[3:0]}).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_regfile_pipe;

`ifdef ALU_PIPE_FWD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [4:0]  flags;
    logic        illegal_op;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    alu_regfile_pipe u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flags      (flags),
        .illegal_op (illegal_op)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction; returns just after its accepting edge
    task automatic send(input logic [15:0] instr, output int stalls);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = instr;
        stalls   = 0;
        while (!in_ready && stalls < 20) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 20) check_eq("send_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_wb(input string tag, input logic [3:0] addr, input logic [15:0] data);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (wb_valid) break;
        end
        check_eq({tag, "_wbv"}, wb_valid, 1);
        check_eq({tag, "_wba"}, wb_addr, addr);
        check_eq({tag, "_wbd"}, wb_data, data);
    endtask

    task automatic exec_wr(input string tag, input logic [15:0] instr,
                           input logic [3:0] addr, input logic [15:0] data);
        int st;
        send(instr, st);
        expect_wb(tag, addr, data);
    endtask

    task automatic wait_mem_req();
        for (int n = 0; n < 8; n++) begin
            if (mem_req) break;
            @(negedge clk);
        end
    endtask

    // LOAD rd <- mem[reg rs], memory answers 'delay' cycles after mem_req
    task automatic do_load(input string tag, input logic [3:0] rd, input logic [3:0] rs,
                           input logic [15:0] exp_addr, input logic [15:0] data, input int delay);
        int st;
        send({8'h99, rd, rs}, st);
        wait_mem_req();
        check_eq({tag, "_mreq"}, mem_req, 1);
        check_eq({tag, "_maddr"}, mem_addr, exp_addr);
        for (int i = 0; i < delay; i++) begin
            check_eq({tag, "_stall_rdy"}, in_ready, 0);
            @(negedge clk);
        end
        mem_valid = 1'b1;
        mem_data  = data;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_data  = 16'h0000;
        @(negedge clk);
        check_eq({tag, "_wbv"}, wb_valid, 1);
        check_eq({tag, "_wba"}, wb_addr, rd);
        check_eq({tag, "_wbd"}, wb_data, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int st;
        int cnt_wb;
        int cnt_ill;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'h0000;
        mem_valid = 1'b0;
        mem_data  = 16'h0000;

        // ---- reset state
        repeat (3) @(negedge clk);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_illegal", illegal_op, 0);
        check_eq("rst_flags", flags, 5'h00);
        reset = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready, 1);

        // ---- ADDI r1,#5: write-back exactly two edges after accept
        send(16'h0115, st);
        @(negedge clk);
        check_eq("addi_lat_e0", wb_valid, 0);
        @(negedge clk);
        check_eq("addi_lat_e1", wb_valid, 0);
        @(negedge clk);
        check_eq("addi_wbv", wb_valid, 1);
        check_eq("addi_wba", wb_addr, 4'd1);
        check_eq("addi_wbd", wb_data, 16'h0005);
        check_eq("addi_flags", flags, 5'h00);
        @(negedge clk);
        check_eq("addi_wb_pulse", wb_valid, 0);

        // ---- r1 = 0x7FFF then ADD r1,r1 -> signed overflow
        do_load("ld_r1", 4'd1, 4'd0, 16'h0000, 16'h7FFF, 0);
        exec_wr("add_ovf", 16'h0011, 4'd1, 16'hFFFE);
        check_eq("add_ovf_flags", flags, 5'b00100);

        // ---- back-to-back dependent pair
        send(16'h0123, st);
        send(16'h0022, st);
        check_eq("hz_accept_stalls", st, 0);
        @(negedge clk);
        check_eq("hz_ready_bubble", in_ready, c_FWD ? 1 : 0);
        check_eq("hz_wb_early", wb_valid, 0);
        @(negedge clk);
        check_eq("hz_ready_back", in_ready, 1);
        check_eq("hz_addi_wbv", wb_valid, 1);
        check_eq("hz_addi_wbd", wb_data, 16'h0003);
        expect_wb("hz_add", 4'd2, 16'h0006);

        // ---- LOAD r3 = 0x0010, then LOAD r4 from r3 with slow memory
        do_load("ld_r3", 4'd3, 4'd0, 16'h0000, 16'h0010, 0);
        do_load("ld_r4", 4'd4, 4'd3, 16'h0010, 16'hBEEF, 3);

        // ---- CMP r5=0xFFFF vs r6=0x0001
        exec_wr("set_r5", 16'h015F, 4'd5, 16'hFFFF);
        exec_wr("set_r6", 16'h0161, 4'd6, 16'h0001);
        send(16'h0A56, st);
        cnt_wb = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb_valid) cnt_wb++;
        end
        check_eq("cmp_no_wb", cnt_wb, 0);
        check_eq("cmp_flags", flags, 5'b00001);
        exec_wr("and", 16'h0D56, 4'd5, 16'h0001);
        check_eq("and_flags_hold", flags, 5'b00001);

        // ---- illegal opcode
        send(16'h5570, st);
        cnt_wb  = 0;
        cnt_ill = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb_valid) cnt_wb++;
            if (illegal_op) cnt_ill++;
        end
        check_eq("ill_pulses", cnt_ill, 1);
        check_eq("ill_no_wb", cnt_wb, 0);
        check_eq("ill_flags_hold", flags, 5'b00001);

        // ---- reset in the middle of a stalled LOAD r7
        send(16'h9973, st);
        wait_mem_req();
        check_eq("mid_mreq", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_mreq", mem_req, 0);
        check_eq("mid_rst_wbv", wb_valid, 0);
        check_eq("mid_rst_flags", flags, 5'h00);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_ready", in_ready, 1);
        exec_wr("r7_zero", 16'h0170, 4'd7, 16'h0000);
        exec_wr("r4_zero", 16'h0140, 4'd4, 16'h0000);
        exec_wr("r3_zero", 16'h0130, 4'd3, 16'h0000);

        // ---- SUBI zero-extended immediate, ADDU carry, shifts by 0 (=1)
        exec_wr("subi", 16'h099F, 4'd9, 16'hFFF1);
        exec_wr("addu", 16'h0299, 4'd9, 16'hFFE2);
        check_eq("addu_flags", flags, 5'b01000);
        exec_wr("set_r8", 16'h0183, 4'd8, 16'h0003);
        exec_wr("lsh0", 16'h1180, 4'd8, 16'h0006);
        exec_wr("set_r5b", 16'h015F, 4'd5, 16'hFFFF);
        exec_wr("arsh0", 16'h1650, 4'd5, 16'hFFFF);
        exec_wr("rsh0", 16'h1350, 4'd5, 16'h7FFF);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
